// File: rtl/prim_dispatcher_if.sv
// Command handshake bundle between the host command queue and prim_dispatcher.
//   cmd_valid      command present (host -> dispatcher)
//   cmd_ready      dispatcher accepts the command this cycle (dispatcher -> host)
//   cmd_type       0 = line, 1 = circle, 2/3 = illegal
//   cmd_positions  {x0[9:0], y0[8:0], x1_or_r[9:0], y1[8:0]}
//   cmd_color      pixel colour for the whole primitive
// The master modport is the host side; the slave modport is the dispatcher side.
interface prim_dispatcher_if #(
  parameter int unsigned COLOR_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [37:0]        cmd_positions;
  logic [COLOR_W-1:0] cmd_color;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_positions,
    output cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_positions,
    input  cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/prim_dispatcher.sv
// prim_dispatcher: sequences draw commands onto the line and circle rasterizer
// engines and forwards the selected engine's pixel addresses to the framebuffer
// write port, holding the engine while the framebuffer is busy.
//
// Ports
//   clk, rst        system clock (rising edge), synchronous active-high reset
//   cmd             command handshake (slave side of prim_dispatcher_if)
//   eng_positions   latched positions shared by both engines
//   line_go/circ_go one-cycle start pulse for the line/circle engine
//   eng_stop        engine hold: framebuffer busy or timeout abort cycle
//   line_*/circ_*   pixel address, address valid and finished from each engine
//   fb_busy         framebuffer cannot accept a write this cycle
//   fb_we/addr/data registered framebuffer write port
//   prim_done       one-cycle pulse when a primitive completes
//   cmd_err         one-cycle pulse on illegal command type or timeout abort
//   prim_count      completed primitives (wrapping)
//   clip_count      dropped out-of-range pixels (saturating)
module prim_dispatcher #(
  parameter int unsigned FB_W    = 640,
  parameter int unsigned FB_H    = 480,
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic               clk,
  input  logic               rst,
  prim_dispatcher_if.slave   cmd,
  output logic [37:0]        eng_positions,
  output logic               line_go,
  output logic               circ_go,
  output logic               eng_stop,
  input  logic [18:0]        line_addr,
  input  logic               line_pvalid,
  input  logic               line_done,
  input  logic [18:0]        circ_addr,
  input  logic               circ_pvalid,
  input  logic               circ_done,
  input  logic               fb_busy,
  output logic               fb_we,
  output logic [18:0]        fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               prim_done,
  output logic               cmd_err,
  output logic [15:0]        prim_count,
  output logic [15:0]        clip_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned FB_SIZE = FB_W * FB_H;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]         state_q;
  logic               circ_sel_q;   // latched type: 1 = circle, 0 = line
  logic [COLOR_W-1:0] color_q;
  logic [37:0]        pos_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               fb_we_q;
  logic [18:0]        fb_addr_q;
  logic [COLOR_W-1:0] fb_data_q;
  logic [15:0]        prim_count_q;
  logic [15:0]        clip_count_q;

  logic        accept;
  logic        legal;
  logic        in_draw;
  logic [18:0] sel_addr;
  logic        sel_pvalid;
  logic        sel_done;
  logic        timeout_hit;
  logic        pix_take;
  logic        in_range;

  // Only the engine chosen by the latched type is observed.
  always_comb begin
    sel_addr   = line_addr;
    sel_pvalid = line_pvalid;
    sel_done   = line_done;
    if (circ_sel_q) begin
      sel_addr   = circ_addr;
      sel_pvalid = circ_pvalid;
      sel_done   = circ_done;
    end
  end

  // State-decoded outputs are masked by rst so nothing is asserted while reset
  // is held, even though the state register only clears on the next edge.
  always_comb begin
    cmd.cmd_ready = (state_q == S_IDLE) && !rst;
    in_draw       = (state_q == S_DRAW) && !rst;
    accept        = cmd.cmd_valid && cmd.cmd_ready;
    legal         = !cmd.cmd_type[1];
    // A done arriving in the last allowed cycle wins over the abort.
    timeout_hit   = in_draw && !sel_done && (cnt_q == CNT_LAST);
    // The engine is being held during the abort cycle, so its pixel is not taken.
    pix_take      = in_draw && sel_pvalid && !fb_busy && !timeout_hit;
    in_range      = (32'(sel_addr) < FB_SIZE);
    line_go       = (state_q == S_START) && !circ_sel_q && !rst;
    circ_go       = (state_q == S_START) &&  circ_sel_q && !rst;
    eng_stop      = in_draw && (fb_busy || timeout_hit);
    prim_done     = (state_q == S_DONE) && !rst;
    // Illegal-type errors are registered; the timeout error coincides with
    // the abort cycle itself.
    cmd_err       = err_q || timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      circ_sel_q   <= 1'b0;
      color_q      <= '0;
      pos_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      prim_count_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (legal) begin
              circ_sel_q <= cmd.cmd_type[0];
              pos_q      <= cmd.cmd_positions;
              color_q    <= cmd.cmd_color;
              state_q    <= S_START;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (sel_done) begin
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          prim_count_q <= prim_count_q + 16'd1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Framebuffer write port and clip counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      clip_count_q <= '0;
    end else begin
      fb_we_q <= pix_take && in_range;
      if (pix_take && in_range) begin
        fb_addr_q <= sel_addr;
        fb_data_q <= color_q;
      end
      if (pix_take && !in_range && (clip_count_q != 16'hFFFF)) begin
        clip_count_q <= clip_count_q + 16'd1;
      end
    end
  end

  assign eng_positions = pos_q;
  assign fb_we         = fb_we_q;
  assign fb_addr       = fb_addr_q;
  assign fb_data       = fb_data_q;
  assign prim_count    = prim_count_q;
  assign clip_count    = clip_count_q;

endmodule

// File: tb/tb_prim_dispatcher.sv
// Self-checking bench for prim_dispatcher (TIMEOUT = 16). Framebuffer writes
// are checked through a scoreboard queue filled when a pixel is offered to the
// dispatcher and drained by a monitor on every fb_we; control pulses are
// checked by directed comparisons and by pulse counters kept in the monitor.
module tb_prim_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [37:0] eng_positions;
  logic        line_go, circ_go, eng_stop;
  logic [18:0] line_addr, circ_addr;
  logic        line_pvalid, line_done, circ_pvalid, circ_done;
  logic        fb_busy;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        prim_done, cmd_err;
  logic [15:0] prim_count, clip_count;

  prim_dispatcher_if #(.COLOR_W(8)) cmd_if ();

  prim_dispatcher #(
    .FB_W(640), .FB_H(480), .COLOR_W(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if),
    .eng_positions(eng_positions), .line_go(line_go), .circ_go(circ_go),
    .eng_stop(eng_stop),
    .line_addr(line_addr), .line_pvalid(line_pvalid), .line_done(line_done),
    .circ_addr(circ_addr), .circ_pvalid(circ_pvalid), .circ_done(circ_done),
    .fb_busy(fb_busy), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .prim_done(prim_done), .cmd_err(cmd_err),
    .prim_count(prim_count), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_line_go = 0, n_circ_go = 0, n_prim_done = 0;
  logic [26:0] exp_q[$];
  logic [7:0]  cur_color = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor and pulse counters.
  always @(negedge clk) begin
    if (line_go)   n_line_go++;
    if (circ_go)   n_circ_go++;
    if (prim_done) n_prim_done++;
    if (fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("fb_unexpected_write", 64'({fb_addr, fb_data}), 64'h0);
      end else begin
        check("fb_write", 64'({fb_addr, fb_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [37:0] pk(input int x0, input int y0, input int x1, input int y1);
    return {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One DRAW cycle on the selected engine; expected writes go to the scoreboard.
  task automatic pix(input bit circ, input logic v, input logic [18:0] a,
                     input logic busy, input logic d);
    fb_busy = busy;
    if (circ) begin circ_pvalid = v; circ_addr = a; circ_done = d; end
    else      begin line_pvalid = v; line_addr = a; line_done = d; end
    if (v && !busy && (a < 19'd307200)) exp_q.push_back({a, cur_color});
    @(negedge clk);
    check("eng_stop_vs_busy", 64'(eng_stop), 64'(busy));
    cyc();
    fb_busy = 1'b0;
    if (circ) begin circ_pvalid = 1'b0; circ_done = 1'b0; end
    else      begin line_pvalid = 1'b0; line_done = 1'b0; end
  endtask

  // Present one command in IDLE; returns at the start of the next cycle.
  task automatic send(input logic [1:0] t, input logic [37:0] p, input logic [7:0] c);
    cmd_if.cmd_valid     = 1'b1;
    cmd_if.cmd_type      = t;
    cmd_if.cmd_positions = p;
    cmd_if.cmd_color     = c;
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_if.cmd_ready), 64'd1);
    cyc();
    cmd_if.cmd_valid = 1'b0;
    if (!t[1]) cur_color = c;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_line_go"},    64'(line_go), 64'd0);
    check({tag, "_circ_go"},    64'(circ_go), 64'd0);
    check({tag, "_eng_stop"},   64'(eng_stop), 64'd0);
    check({tag, "_fb_we"},      64'(fb_we), 64'd0);
    check({tag, "_fb_addr"},    64'(fb_addr), 64'd0);
    check({tag, "_fb_data"},    64'(fb_data), 64'd0);
    check({tag, "_prim_done"},  64'(prim_done), 64'd0);
    check({tag, "_cmd_err"},    64'(cmd_err), 64'd0);
    check({tag, "_prim_count"}, 64'(prim_count), 64'd0);
    check({tag, "_clip_count"}, 64'(clip_count), 64'd0);
    check({tag, "_eng_pos"},    64'(eng_positions), 64'd0);
  endtask

  initial begin
    int lg0, cg0, pd0;
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_type = 2'd0;
    cmd_if.cmd_positions = '0; cmd_if.cmd_color = '0;
    line_addr = '0; line_pvalid = 1'b0; line_done = 1'b0;
    circ_addr = '0; circ_pvalid = 1'b0; circ_done = 1'b0;
    fb_busy = 1'b0;
    cyc();
    @(negedge clk);
    check_all_zero("reset");
    check("reset_cmd_ready", 64'(cmd_if.cmd_ready), 64'd0);
    cyc();
    rst = 1'b0;

    // T1: circle; line engine noise (including done) must be ignored.
    lg0 = n_line_go; cg0 = n_circ_go; pd0 = n_prim_done;
    send(2'd1, pk(320, 240, 100, 0), 8'hA5);
    line_pvalid = 1'b1; line_addr = 19'd5; line_done = 1'b1;
    circ_done = 1'b1;   // done during START is ignored
    @(negedge clk);
    check("t1_circ_go", 64'(circ_go), 64'd1);
    check("t1_line_go", 64'(line_go), 64'd0);
    check("t1_eng_pos", 64'(eng_positions), 64'(pk(320, 240, 100, 0)));
    check("t1_ready_busy", 64'(cmd_if.cmd_ready), 64'd0);
    cyc();
    circ_done = 1'b0;
    pix(1, 1, 19'd154020, 0, 0);
    pix(1, 1, 19'd154021, 0, 0);
    pix(1, 1, 19'd89920, 0, 0);
    pix(1, 0, 19'd0, 0, 0);
    pix(1, 1, 19'd217920, 0, 1);
    @(negedge clk);
    check("t1_prim_done", 64'(prim_done), 64'd1);
    check("t1_ready_in_done", 64'(cmd_if.cmd_ready), 64'd0);
    cyc();
    line_pvalid = 1'b0; line_done = 1'b0;
    check("t1_prim_count", 64'(prim_count), 64'd1);
    check("t1_circ_go_count", 64'(n_circ_go - cg0), 64'd1);
    check("t1_line_go_count", 64'(n_line_go - lg0), 64'd0);
    check("t1_done_count", 64'(n_prim_done - pd0), 64'd1);
    @(negedge clk);
    check("t1_ready_after", 64'(cmd_if.cmd_ready), 64'd1);
    cyc();

    // T2: line with a five-cycle framebuffer stall.
    send(2'd0, pk(0, 0, 639, 479), 8'h5A);
    @(negedge clk);
    check("t2_line_go", 64'(line_go), 64'd1);
    check("t2_circ_go", 64'(circ_go), 64'd0);
    cyc();
    pix(0, 1, 19'd0, 0, 0);
    pix(0, 1, 19'd641, 0, 0);
    pix(0, 1, 19'd1282, 0, 0);
    for (int i = 0; i < 5; i++) pix(0, 1, 19'd1923, 1, 0);
    pix(0, 1, 19'd1923, 0, 0);
    pix(0, 1, 19'd2564, 0, 1);
    cyc();
    check("t2_prim_count", 64'(prim_count), 64'd2);

    // T3: illegal type.
    lg0 = n_line_go; cg0 = n_circ_go;
    send(2'd2, pk(1, 2, 3, 4), 8'hFF);
    @(negedge clk);
    check("t3_cmd_err", 64'(cmd_err), 64'd1);
    check("t3_cmd_ready", 64'(cmd_if.cmd_ready), 64'd1);
    cyc();
    @(negedge clk);
    check("t3_cmd_err_clear", 64'(cmd_err), 64'd0);
    cyc();
    check("t3_prim_count", 64'(prim_count), 64'd2);
    check("t3_no_go", 64'((n_line_go - lg0) + (n_circ_go - cg0)), 64'd0);
    check("t3_pos_kept", 64'(eng_positions), 64'(pk(0, 0, 639, 479)));

    // T4: clipping at the framebuffer end.
    send(2'd0, pk(639, 479, 639, 479), 8'h3C);
    cyc();
    pix(0, 1, 19'd307200, 0, 0);
    pix(0, 1, 19'd307199, 0, 1);
    cyc();
    check("t4_clip_count", 64'(clip_count), 64'd1);
    check("t4_prim_count", 64'(prim_count), 64'd3);

    // T5: timeout, engine never finishes.
    pd0 = n_prim_done;
    send(2'd1, pk(100, 100, 20, 0), 8'h11);
    @(negedge clk);
    check("t5_circ_go", 64'(circ_go), 64'd1);
    cyc();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("t5_eng_stop", 64'(eng_stop), 64'(k == 16));
      check("t5_cmd_err", 64'(cmd_err), 64'(k == 16));
      check("t5_cmd_ready", 64'(cmd_if.cmd_ready), 64'(k == 17));
      cyc();
    end
    check("t5_prim_count", 64'(prim_count), 64'd3);
    check("t5_no_done", 64'(n_prim_done - pd0), 64'd0);

    // T6: reset mid-draw, then a normal command.
    send(2'd0, pk(10, 0, 20, 0), 8'h77);
    cyc();
    pix(0, 1, 19'd10, 0, 0);
    rst = 1'b1; line_pvalid = 1'b1; line_addr = 19'd12;
    cyc();
    rst = 1'b0; line_pvalid = 1'b0;
    @(negedge clk);
    check_all_zero("t6");
    check("t6_cmd_ready", 64'(cmd_if.cmd_ready), 64'd1);
    cyc();
    send(2'd1, pk(320, 240, 5, 0), 8'h42);
    @(negedge clk);
    check("t6_circ_go", 64'(circ_go), 64'd1);
    cyc();
    pix(1, 1, 19'd100, 0, 1);
    @(negedge clk);
    check("t6_prim_done", 64'(prim_done), 64'd1);
    cyc();
    check("t6_prim_count", 64'(prim_count), 64'd1);

    cyc();
    cyc();
    check("fb_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
